job_seq: RTL and testbench
==========================

JOB_SEQ -- requirements
Module: job_seq

Interface
REQ-001 SHALL have parameter ITEM_W, default 16, width of item count and mat_a.
REQ-002 SHALL have parameter BEAT_W, default 20, width of the expected-beat count and the beat counter.
REQ-003 SHALL have parameter TMO_CYC, default 1024, idle-cycle limit in RUN (used only with JOB_SEQ_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  sole clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  job start request, sampled in IDLE only.
REQ-007 SHALL have port abort  in  1  cancels any job in progress.
REQ-008 SHALL have port item_num  in  ITEM_W  last item-memory index to generate (count = item_num+1).
REQ-009 SHALL have port beat_num  in  BEAT_W  expected output beats per job, nonzero.
REQ-010 SHALL have ports dst_valid, dst_ready, dst_last  in  1 each  monitored output-stream handshake.
REQ-011 SHALL have port matw  out  1  item-memory generation enable to core and rng.
REQ-012 SHALL have port mat_a  out  ITEM_W  item-memory write address.
REQ-013 SHALL have port run  out  1  execution enable to stream controllers.
REQ-014 SHALL have ports busy, done, err  out  1 each  job in progress / completion pulse / sticky error.
REQ-015 SHALL have port state  out  3  current FSM state encoding.

Function
REQ-016 SHALL register all outputs; no combinational input-to-output path.
REQ-017 SHALL implement states IDLE=0, GEN=1, RUN=2, DONE=3; codes 4-7 unused, decoded to IDLE next cycle.
REQ-018 SHALL, in IDLE with start=1 and abort=0, latch item_num and beat_num, clear err, and enter GEN next cycle (matw=1 one cycle after start).
REQ-019 SHALL, in GEN, drive matw=1, starting mat_a at 0 and incrementing it by 1 per cycle.
REQ-020 SHALL leave GEN when mat_a equals latched item_num, giving exactly item_num+1 matw cycles; matw=0 and run=1 from the next cycle.
REQ-021 SHALL, in RUN, drive run=1 and count accepted beats (dst_valid & dst_ready) in a BEAT_W counter cleared on RUN entry.
REQ-022 SHALL go to DONE on an accepted beat with dst_last=1; ignore dst_last without dst_ready.
REQ-023 SHALL set err if the final accepted beat count (including the last beat) differs from latched beat_num.
REQ-024 SHALL set err and go to IDLE if the counter reaches beat_num with no dst_last.
REQ-025 SHALL, in DONE, drive run=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive busy=1 in GEN and RUN, 0 otherwise.
REQ-027 SHALL ignore start outside IDLE; item_num/beat_num changes after latching SHALL have no effect.
REQ-028 SHALL, on abort in GEN or RUN, go to IDLE next cycle, clear matw and run, set err, suppress done.
REQ-029 SHALL give abort priority over start when both are asserted in IDLE; stay in IDLE with err unchanged.
REQ-030 SHALL let abort in DONE take no effect; done still pulses.
REQ-031 SHALL hold mat_a at 0 in IDLE, RUN and DONE; mat_a wrap SHALL be impossible because the GEN exit compare precedes overflow.

Reset
REQ-032 SHALL, while rst=1, force state=IDLE, matw=0, mat_a=0, run=0, busy=0, done=0, err=0, beat counter=0, timeout counter=0.
REQ-033 SHALL let rst mid-job override everything, with no done pulse; the first start after rst release SHALL be accepted normally.

Configuration
REQ-034 SHALL, with JOB_SEQ_TIMEOUT_EN defined, count RUN cycles since RUN entry or the last accepted beat, and at TMO_CYC set err and go to IDLE.
REQ-035 SHALL, without JOB_SEQ_TIMEOUT_EN, include no timeout counter and never leave RUN except per REQ-022/024/028.

Verification
REQ-036 SHALL cover: item_num=99, beat_num=8, 8 beats last on 8th -> matw high 100 cycles, mat_a 0..99, run 1 cycle later, done one-cycle pulse, err=0.
REQ-037 SHALL cover: item_num=0, beat_num=1 -> matw exactly 1 cycle, one beat with last -> done, err=0.
REQ-038 SHALL cover: beat_num=8, dst_last on 5th accepted beat -> DONE, done pulse, err=1; dst_ready=0 with last -> stay in RUN.
REQ-039 SHALL cover: abort at GEN cycle 10, and start+abort in IDLE -> matw/run low next cycle, err=1, no done; IDLE stays IDLE.
REQ-040 SHALL cover: JOB_SEQ_TIMEOUT_EN, TMO_CYC=16, no beats in RUN -> err=1 and IDLE after 16 cycles; undefined -> stays in RUN.
REQ-041 SHALL cover: rst asserted in RUN -> all outputs at reset values next cycle, no done; a new job afterwards completes.

Source files
------------

// File: rtl/job_seq_if.sv
// job_seq_if: job control inputs, monitored stream handshake and status outputs of job_seq
interface job_seq_if #(
  parameter int ITEM_W = 16,
  parameter int BEAT_W = 20
);
  logic              start;
  logic              abort;
  logic [ITEM_W-1:0] item_num;
  logic [BEAT_W-1:0] beat_num;
  logic              dst_valid;
  logic              dst_ready;
  logic              dst_last;
  logic              matw;
  logic [ITEM_W-1:0] mat_a;
  logic              run;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state;
  modport master (
    output start, abort, item_num, beat_num, dst_valid, dst_ready, dst_last,
    input  matw, mat_a, run, busy, done, err, state
  );
  modport slave (
    input  start, abort, item_num, beat_num, dst_valid, dst_ready, dst_last,
    output matw, mat_a, run, busy, done, err, state
  );
endinterface

// File: rtl/job_seq.sv
// job_seq: IDLE->GEN->RUN->DONE job sequencer; JOB_SEQ_TIMEOUT_EN adds a RUN idle timeout of TMO_CYC cycles
module job_seq #(
  parameter int ITEM_W  = 16,
  parameter int BEAT_W  = 20,
  parameter int TMO_CYC = 1024
) (
  input  logic     clk,
  input  logic     rst,
  job_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, GEN = 3'd1, RUN = 3'd2, DONE = 3'd3} state_t;
  state_t            state_q, state_d;
  logic [ITEM_W-1:0] item_q, item_d, mat_a_q, mat_a_d;
  logic [BEAT_W-1:0] beat_q, beat_d, cnt_q, cnt_d, cnt_inc;
  logic              matw_q, matw_d, run_q, run_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              acc, tmo_hit;
  assign acc     = bus.dst_valid & bus.dst_ready;
  assign cnt_inc = cnt_q + 1'b1;
`ifdef JOB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc = tmo_q + 1'b1;
  assign tmo_hit = tmo_inc == TW'(TMO_CYC);
  assign tmo_d   = (state_q == RUN && !acc) ? tmo_inc : '0;
  // idle-cycle counter, restarted on RUN entry and on every accepted beat
  always_ff @(posedge clk)
    tmo_q <= rst ? '0 : tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = TMO_CYC != 0;
  assign tmo_hit    = 1'b0;
`endif
  // next state, job latches, beat count and sticky error; outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mat_a_d = '0;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = GEN;
        item_d  = bus.item_num;
        beat_d  = bus.beat_num;
        err_d   = 1'b0;
      end
      GEN: if (bus.abort) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (mat_a_q == item_q) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        mat_a_d = mat_a_q + 1'b1;
      end
      RUN: if (bus.abort) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (acc) begin
        cnt_d = cnt_inc;
        if (bus.dst_last) begin
          state_d = DONE;
          err_d   = err_q | (cnt_inc != beat_q);
        end else if (cnt_inc == beat_q) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end else if (tmo_hit) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    matw_d = state_d == GEN;
    run_d  = state_d == RUN;
    busy_d = matw_d | run_d;
    done_d = state_d == DONE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      item_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      mat_a_q <= '0;
      matw_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      matw_q  <= matw_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.state = state_q;
  assign bus.matw  = matw_q;
  assign bus.mat_a = mat_a_q;
  assign bus.run   = run_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_job_seq.sv
// tb_job_seq: randomized job scoreboard bench for job_seq
module tb_job_seq;
  localparam int IW = 16;
  localparam int BW = 20;
  localparam int TMO = 16;
`ifdef JOB_SEQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  typedef struct {
    int matw_n;
    bit run_seen;
    bit done;
    bit err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   jobs_pushed = 0, jobs_seen = 0, exp_done_tot = 0, obs_done_tot = 0, idle_addr_bad = 0;
  bit   model_err = 1'b0;
  exp_t sb[$];
  job_seq_if #(.ITEM_W(IW), .BEAT_W(BW)) bus ();
  job_seq #(.ITEM_W(IW), .BEAT_W(BW), .TMO_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: tracks each job from busy rise to busy fall and scores it against the queue
  bit   in_job = 1'b0, prev_matw = 1'b0, run_seen = 1'b0;
  int   matw_n = 0, addr_bad = 0, gap_bad = 0;
  exp_t e;
  always @(negedge clk) begin
    if (bus.done) obs_done_tot++;
    if (!bus.matw && bus.mat_a != '0) idle_addr_bad++;
    if (bus.busy && !in_job) begin
      in_job   = 1'b1;
      matw_n   = 0;
      addr_bad = 0;
      gap_bad  = 0;
      run_seen = 1'b0;
    end
    if (in_job) begin
      if (bus.matw) begin
        if (bus.mat_a != IW'(matw_n)) addr_bad++;
        matw_n++;
      end
      if (bus.run && !run_seen) begin
        run_seen = 1'b1;
        if (!prev_matw) gap_bad++;
      end
      if (!bus.busy) begin
        in_job = 1'b0;
        jobs_seen++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("matw_cycles", matw_n, e.matw_n);
          chk("mat_a_seq_bad", addr_bad, 0);
          chk("run_seen", run_seen, e.run_seen);
          chk("run_gap_bad", gap_bad, 0);
          chk("end_state", bus.state, e.done ? 3 : 0);
          chk("done", bus.done, e.done);
          chk("err", bus.err, e.err);
          chk("end_outs", {bus.matw, bus.run, bus.mat_a}, 0);
        end
      end
    end
    prev_matw = bus.matw;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic clr();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dst_valid = 1'b0;
    bus.dst_ready = 1'b0;
    bus.dst_last = 1'b0;
  endtask
  // kinds: 0 last on beat_num, 1 last on k-th beat, 2 never last, 3 abort at GEN cycle k,
  // 4 abort in RUN after k beats, 5 rst in RUN after k beats, 6 stall 20 cycles then normal
  task automatic job(input int item, input int beat, input int kind, input int k);
    exp_t x;
    int   n = 0, target;
    bit   fin = 1'b0, acc;
    x.matw_n   = kind == 3 ? k : item + 1;
    x.run_seen = kind != 3;
    x.done     = kind == 0 || kind == 1 || (kind == 6 && !TMO_ON);
    x.err      = kind == 1 ? (k != beat) : (kind inside {2, 3, 4} || (kind == 6 && TMO_ON));
    sb.push_back(x);
    jobs_pushed++;
    if (x.done) exp_done_tot++;
    model_err = x.err;
    bus.start = 1'b1;
    bus.item_num = IW'(item);
    bus.beat_num = BW'(beat);
    cyc();
    bus.start = 1'b0;
    bus.item_num = IW'($urandom);
    bus.beat_num = BW'($urandom);
    if (kind == 3) begin
      idle(k - 1);
      bus.abort = 1'b1;
      cyc();
      bus.abort = 1'b0;
      idle(3);
      return;
    end
    for (int i = 0; i < 400 && !bus.run; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.start = 1'b0;
    chk("run_wait", bus.run, 1);
    if (kind == 6) begin
      idle(20);
      chk("stall_state", bus.state, TMO_ON ? 0 : 2);
      if (TMO_ON) begin
        idle(3);
        return;
      end
    end
    target = kind == 1 ? k : (kind == 0 || kind == 6) ? beat : 0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      if ((kind == 4 || kind == 5) && n == k) begin
        clr();
        if (kind == 4) begin
          bus.abort = 1'b1;
          cyc();
          bus.abort = 1'b0;
        end else begin
          rst = 1'b1;
          idle(2);
          rst = 1'b0;
        end
        fin = 1'b1;
      end else begin
        bus.dst_valid = 1'($urandom_range(0, 3) != 0);
        bus.dst_ready = 1'($urandom_range(0, 3) != 0);
        acc = bus.dst_valid & bus.dst_ready;
        bus.dst_last = acc ? 1'(n + 1 == target) : 1'($urandom_range(0, 2) == 0);
        cyc();
        if (acc) begin
          n++;
          fin = n == target || (target == 0 && n == beat);
        end
      end
    end
    chk("beat_loop_end", fin, 1);
    clr();
    idle(3);
  endtask
  task automatic idle_abort();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.item_num = IW'($urandom_range(0, 20));
    bus.beat_num = BW'($urandom_range(1, 10));
    cyc();
    clr();
    chk("idle_abort_state", bus.state, 0);
    chk("idle_abort_busy", bus.busy, 0);
    chk("idle_abort_err", bus.err, model_err);
    cyc();
    chk("idle_abort_matw", bus.matw, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int kind, item, beat, k;
    clr();
    bus.item_num = '0;
    bus.beat_num = '0;
    idle(2);
    chk("rst_outs", {bus.state, bus.matw, bus.mat_a, bus.run, bus.busy, bus.done, bus.err}, 0);
    rst = 1'b0;
    idle(2);
    job(99, 8, 0, 0);
    job(0, 1, 0, 0);
    job(5, 8, 1, 5);
    job(99, 8, 3, 10);
    idle_abort();
    job(3, 8, 6, 0);
    job(4, 6, 5, 2);
    job(2, 3, 0, 0);
    job(3, 4, 2, 0);
    job(3, 6, 4, 3);
    repeat (40) begin
      kind = $urandom_range(0, 7);
      item = $urandom_range(0, 30);
      beat = $urandom_range(1, 10);
      k = kind == 1 ? $urandom_range(1, beat) :
          kind == 3 ? $urandom_range(1, item + 1) :
          (kind == 4 || kind == 5) ? $urandom_range(0, beat - 1) : 0;
      if (kind == 7) idle_abort();
      else job(item, beat, kind, k);
    end
    idle(5);
    chk("jobs_seen", jobs_seen, jobs_pushed);
    chk("done_total", obs_done_tot, exp_done_tot);
    chk("idle_mat_a_bad", idle_addr_bad, 0);
    chk("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
